// File: rtl/amm_arbiter_if.sv
// amm_arbiter_if
//   One Avalon-MM link: command from the master side, waitrequest and the
//   read response back from the slave side.
//
//   Parameters:
//     ADDR_W  address width
//     DATA_W  data width; byteenable carries DATA_W/8 lanes
//
//   Signals:
//     address, read, write, writedata, byteenable   master -> slave
//     waitrequest, readdata, readdatavalid           slave  -> master
//
//   Modports:
//     master  the side that issues commands
//     slave   the side that accepts commands and returns read data
interface amm_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/amm_arbiter.sv
// amm_arbiter
//   Shares one Avalon-MM slave between two masters. Arbitration is
//   round-robin and happens every cycle. While the slave stalls, the grant
//   stays with the master that is waiting. The command path is purely
//   combinational, so the arbiter adds no latency. A small FIFO of 1-bit
//   master ids follows the outstanding reads, so that each readdatavalid
//   is sent back to the master that issued that read.
//
//   Parameters:
//     ADDR_W       address width
//     DATA_W       data width (byteenable is DATA_W/8)
//     MAX_PENDING  maximum number of outstanding reads (>= 1)
//
//   Ports:
//     clk_i    clock; all state changes on the rising edge
//     rst_n_i  asynchronous, active-low reset
//     m0, m1   master-facing links (arbiter acts as their slave)
//     s        slave-facing link (arbiter acts as its master)
module amm_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_PENDING = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  amm_arbiter_if.slave  m0,
  amm_arbiter_if.slave  m1,
  amm_arbiter_if.master s
);

  localparam int CNT_W = $clog2(MAX_PENDING + 1);
  localparam int PTR_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;

  localparam logic [CNT_W-1:0] PEND_FULL = CNT_W'(MAX_PENDING);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(MAX_PENDING - 1);

  localparam logic GRANT_M0 = 1'b0;
  localparam logic GRANT_M1 = 1'b1;

  // Registered arbitration and read-tracking state
  logic                   last_grant;
  logic                   lock;
  logic                   lock_id;
  logic [CNT_W-1:0]       pending;
  logic [MAX_PENDING-1:0] tag_mem;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;

  // Combinational arbitration results
  logic                req0;
  logic                req1;
  logic                grant_valid;
  logic                grant_id;
  logic                sel_read;
  logic                sel_write;
  logic [ADDR_W-1:0]   sel_address;
  logic [DATA_W-1:0]   sel_writedata;
  logic [DATA_W/8-1:0] sel_byteenable;
  logic                cmd_read;
  logic                cmd_write;
  logic                fifo_full;
  logic                blocked;
  logic                issue;
  logic                accept;
  logic                push;
  logic                pop;
  logic                head_id;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Grant selection. A lock pins the grant to the stalled master, because
  // Avalon requires its command to stay on the bus until it is accepted.
  // Without a lock, a tie goes to the master that was not accepted last.
  always_comb begin
    req0        = m0.read | m0.write;
    req1        = m1.read | m1.write;
    grant_valid = 1'b0;
    grant_id    = last_grant;
    if (lock) begin
      grant_valid = 1'b1;
      grant_id    = lock_id;
    end else if (req0 && req1) begin
      grant_valid = 1'b1;
      grant_id    = ~last_grant;
    end else if (req0) begin
      grant_valid = 1'b1;
      grant_id    = GRANT_M0;
    end else if (req1) begin
      grant_valid = 1'b1;
      grant_id    = GRANT_M1;
    end
  end

  // Command mux and issue decision. If read and write are both high, the
  // command is a write. The full check uses only the registered count, so
  // a response that arrives in the same cycle cannot reach s.read
  // combinationally. The unblock therefore happens one cycle later.
  always_comb begin
    sel_read       = (grant_id == GRANT_M1) ? m1.read       : m0.read;
    sel_write      = (grant_id == GRANT_M1) ? m1.write      : m0.write;
    sel_address    = (grant_id == GRANT_M1) ? m1.address    : m0.address;
    sel_writedata  = (grant_id == GRANT_M1) ? m1.writedata  : m0.writedata;
    sel_byteenable = (grant_id == GRANT_M1) ? m1.byteenable : m0.byteenable;

    cmd_write = grant_valid & sel_write;
    cmd_read  = grant_valid & sel_read & ~sel_write;
    fifo_full = (pending == PEND_FULL);
    blocked   = cmd_read & fifo_full;
    issue     = rst_n_i & (cmd_write | (cmd_read & ~blocked));
    accept    = issue & ~s.waitrequest;

    push      = accept & cmd_read;
    pop       = s.readdatavalid & (pending != '0);
    head_id   = tag_mem[rd_ptr];
  end

  assign s.address    = sel_address;
  assign s.writedata  = sel_writedata;
  assign s.byteenable = sel_byteenable;
  assign s.read       = issue & cmd_read;
  assign s.write      = issue & cmd_write;

  // A master that is not granted always waits. The granted master waits
  // on a slave stall or on a read that is blocked because the FIFO is full.
  assign m0.waitrequest = ~rst_n_i | ~(grant_valid & (grant_id == GRANT_M0))
                          | s.waitrequest | blocked;
  assign m1.waitrequest = ~rst_n_i | ~(grant_valid & (grant_id == GRANT_M1))
                          | s.waitrequest | blocked;

  // Read data goes to both masters. Only the owner of the head tag sees
  // valid. With nothing pending, pop stays low, so a stray response is
  // dropped.
  assign m0.readdata      = s.readdata;
  assign m1.readdata      = s.readdata;
  assign m0.readdatavalid = pop & (head_id == GRANT_M0);
  assign m1.readdatavalid = pop & (head_id == GRANT_M1);

  // Round-robin history and stall lock. An issued command that is not
  // accepted can only be a slave stall, because blocked reads are never
  // issued, so a blocked read cannot lock the grant.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_grant <= GRANT_M1;
      lock       <= 1'b0;
      lock_id    <= GRANT_M0;
    end else if (accept) begin
      last_grant <= grant_id;
      lock       <= 1'b0;
    end else if (issue) begin
      lock       <= 1'b1;
      lock_id    <= grant_id;
    end
  end

  // Tag FIFO and outstanding-read count. A push never meets a full FIFO,
  // because a full FIFO blocks the read before it can be accepted.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tag_mem <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pending <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= grant_id;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   pending <= pending + CNT_W'(1);
        2'b01:   pending <= pending - CNT_W'(1);
        default: pending <= pending;
      endcase
    end
  end

endmodule

// File: tb/tb_amm_arbiter.sv
// tb_amm_arbiter
//   Directed bench for amm_arbiter with MAX_PENDING = 4. A behavioural
//   slave with a word memory, a programmable stall and a programmable read
//   latency sits on the slave link. Expected read data is queued for each
//   master when its read is accepted, and is checked when that master's
//   readdatavalid pulses.
module tb_amm_arbiter;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int MAX_PENDING = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  amm_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_bus ();
  amm_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_bus ();
  amm_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_bus ();

  amm_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .MAX_PENDING(MAX_PENDING)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .m0(m0_bus),
    .m1(m1_bus),
    .s(s_bus)
  );

  // Behavioural slave: 64-word memory, stall input, fixed read latency
  typedef struct {
    logic [31:0] data;
    int          due;
  } resp_t;

  resp_t       rq[$];
  logic [31:0] mem [0:63];
  logic [63:0] memv  = '0;
  int          cyc   = 0;
  int          lat   = 1;
  logic        stall = 1'b0;
  logic        s_rdv = 1'b0;
  logic [31:0] s_rd  = '0;

  assign s_bus.waitrequest   = stall;
  assign s_bus.readdatavalid = s_rdv;
  assign s_bus.readdata      = s_rd;

  function automatic logic [31:0] pattern(input logic [31:0] a);
    return 32'hC0DE0000 | a;
  endfunction

  function logic [31:0] slave_rd(input logic [31:0] a);
    return memv[a[7:2]] ? mem[a[7:2]] : pattern(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // The slave is never reset, so reads that were in flight across a reset
  // of the arbiter still come back afterwards as stray responses.
  always @(posedge clk) begin
    if (s_bus.write && !stall) begin
      mem[s_bus.address[7:2]]  <= merge(slave_rd(s_bus.address), s_bus.writedata, s_bus.byteenable);
      memv[s_bus.address[7:2]] <= 1'b1;
    end else if (s_bus.read && !stall) begin
      rq.push_back('{data: slave_rd(s_bus.address), due: cyc + lat});
    end
    if (rq.size() != 0 && rq[0].due <= cyc + 1) begin
      s_rdv <= 1'b1;
      s_rd  <= rq[0].data;
      void'(rq.pop_front());
    end else begin
      s_rdv <= 1'b0;
    end
    cyc <= cyc + 1;
  end

  // Scoreboard and counters
  logic [31:0] exp0[$];
  logic [31:0] exp1[$];
  int tests      = 0;
  int fails      = 0;
  int tb_cyc     = 0;
  int first_rsp1 = -1;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int k, input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] be);
    if (k == 0) begin
      m0_bus.read = rd; m0_bus.write = wr; m0_bus.address = addr;
      m0_bus.writedata = data; m0_bus.byteenable = be;
    end else begin
      m1_bus.read = rd; m1_bus.write = wr; m1_bus.address = addr;
      m1_bus.writedata = data; m1_bus.byteenable = be;
    end
  endtask

  task automatic idle(input int k);
    apply_stimulus(k, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic check_responses();
    if (m0_bus.readdatavalid === 1'b1) begin
      if (exp0.size() == 0) check_output("m0_unexpected_rdv", 32'(m0_bus.readdatavalid), 32'h0);
      else                  check_output("m0_rdata", m0_bus.readdata, exp0.pop_front());
    end
    if (m1_bus.readdatavalid === 1'b1) begin
      if (first_rsp1 < 0) first_rsp1 = tb_cyc;
      if (exp1.size() == 0) check_output("m1_unexpected_rdv", 32'(m1_bus.readdatavalid), 32'h0);
      else                  check_output("m1_rdata", m1_bus.readdata, exp1.pop_front());
    end
  endtask

  // One clock: inputs set beforehand are sampled on the rising edge, and
  // responses are checked on the following falling edge.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    tb_cyc++;
    check_responses();
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && (exp0.size() != 0 || exp1.size() != 0); i++) cycle();
    check_output({tag, "_drain_m0"}, 32'(exp0.size()), 32'h0);
    check_output({tag, "_drain_m1"}, 32'(exp1.size()), 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp0.delete();
    exp1.delete();
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] g;
    logic [31:0] a0, a1;
    logic        exp_wait;
    int          n0, n1;
    bit          acc;

    idle(0);
    idle(1);

    // Reset state, with m0 driving a read that must stay off the slave bus
    apply_stimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    cycle();
    cycle();
    #1;
    check_output("rst_m0_wait",  32'(m0_bus.waitrequest), 32'h1);
    check_output("rst_m1_wait",  32'(m1_bus.waitrequest), 32'h1);
    check_output("rst_s_read",   32'(s_bus.read), 32'h0);
    check_output("rst_s_write",  32'(s_bus.write), 32'h0);
    check_output("rst_m0_rdv",   32'(m0_bus.readdatavalid), 32'h0);
    check_output("rst_m1_rdv",   32'(m1_bus.readdatavalid), 32'h0);
    idle(0);
    rst_n = 1'b1;
    cycle();

    // m0 writes and then reads the same word on a latency-1 slave
    apply_stimulus(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    #1;
    check_output("t1_wr_wait", 32'(m0_bus.waitrequest), 32'h0);
    check_output("t1_s_write", 32'(s_bus.write), 32'h1);
    check_output("t1_s_addr",  s_bus.address, 32'h10);
    check_output("t1_s_wdata", s_bus.writedata, 32'hDEADBEEF);
    check_output("t1_s_be",    32'(s_bus.byteenable), 32'hF);
    check_output("t1_m1_wait", 32'(m1_bus.waitrequest), 32'h1);
    cycle();
    apply_stimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    #1;
    check_output("t1_rd_wait", 32'(m0_bus.waitrequest), 32'h0);
    check_output("t1_s_read",  32'(s_bus.read), 32'h1);
    if (m0_bus.waitrequest === 1'b0) exp0.push_back(32'hDEADBEEF);
    cycle();
    check_output("t1_rdv_latency", 32'(m0_bus.readdatavalid), 32'h1);
    idle(0);
    cycle();
    cycle();
    drain("t1", 4);

    // Both masters read every cycle; grants must alternate starting at m0
    do_reset();
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 8; i++) begin
      a0 = 32'h40 + 32'(4 * n0);
      a1 = 32'h80 + 32'(4 * n1);
      if (n0 < 4) apply_stimulus(0, 1'b1, 1'b0, a0, 32'h0, 4'hF); else idle(0);
      if (n1 < 4) apply_stimulus(1, 1'b1, 1'b0, a1, 32'h0, 4'hF); else idle(1);
      #1;
      g = (m0_bus.waitrequest === 1'b0) ? 32'h0 : (m1_bus.waitrequest === 1'b0) ? 32'h1 : 32'h2;
      check_output("t2_grant", g, 32'(i % 2));
      if (m0_bus.waitrequest === 1'b0) begin exp0.push_back(pattern(a0)); n0++; end
      if (m1_bus.waitrequest === 1'b0) begin exp1.push_back(pattern(a1)); n1++; end
      check_output("t2_outstanding_le2", 32'(exp0.size() + exp1.size() <= 2), 32'h1);
      cycle();
    end
    idle(0);
    idle(1);
    check_output("t2_m0_count", 32'(n0), 32'h4);
    check_output("t2_m1_count", 32'(n1), 32'h4);
    drain("t2", 8);

    // Preload 0x20 from m0, so that m0 was the last master accepted
    apply_stimulus(0, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF);
    #1;
    check_output("t3_preload_wait", 32'(m0_bus.waitrequest), 32'h0);
    cycle();
    idle(0);

    // Lock under stall: m0 stalls alone, then m1 joins while the stall lasts
    stall = 1'b1;
    apply_stimulus(0, 1'b0, 1'b1, 32'h30, 32'h30303030, 4'hF);
    #1;
    check_output("t3_a_addr",    s_bus.address, 32'h30);
    check_output("t3_a_m0_wait", 32'(m0_bus.waitrequest), 32'h1);
    cycle();
    apply_stimulus(1, 1'b0, 1'b1, 32'h34, 32'h34343434, 4'hF);
    for (int i = 0; i < 2; i++) begin
      #1;
      check_output("t3_locked_addr",    s_bus.address, 32'h30);
      check_output("t3_locked_m1_wait", 32'(m1_bus.waitrequest), 32'h1);
      check_output("t3_locked_m0_wait", 32'(m0_bus.waitrequest), 32'h1);
      cycle();
    end
    stall = 1'b0;
    #1;
    check_output("t3_accept_m0_wait", 32'(m0_bus.waitrequest), 32'h0);
    check_output("t3_accept_addr",    s_bus.address, 32'h30);
    check_output("t3_accept_m1_wait", 32'(m1_bus.waitrequest), 32'h1);
    cycle();
    apply_stimulus(0, 1'b0, 1'b1, 32'h38, 32'h38383838, 4'hF);
    #1;
    check_output("t3_next_m1_wait", 32'(m1_bus.waitrequest), 32'h0);
    check_output("t3_next_addr",    s_bus.address, 32'h34);
    check_output("t3_next_m0_wait", 32'(m0_bus.waitrequest), 32'h1);
    cycle();
    idle(1);
    #1;
    check_output("t3_last_m0_wait", 32'(m0_bus.waitrequest), 32'h0);
    check_output("t3_last_addr",    s_bus.address, 32'h38);
    cycle();
    idle(0);
    cycle();

    // Full FIFO: m1 issues five reads against a latency-10 slave
    lat = 10;
    first_rsp1 = -1;
    for (int i = 0; i < 4; i++) begin
      a1 = 32'h80 + 32'(4 * i);
      apply_stimulus(1, 1'b1, 1'b0, a1, 32'h0, 4'hF);
      #1;
      check_output("t4_rd_wait", 32'(m1_bus.waitrequest), 32'h0);
      if (m1_bus.waitrequest === 1'b0) exp1.push_back(pattern(a1));
      cycle();
    end
    apply_stimulus(1, 1'b1, 1'b0, 32'h90, 32'h0, 4'hF);
    acc = 1'b0;
    for (int i = 0; i < 30 && !acc; i++) begin
      if (i == 1) apply_stimulus(0, 1'b0, 1'b1, 32'h3C, 32'h3C3C3C3C, 4'hF);
      else        idle(0);
      #1;
      exp_wait = !(first_rsp1 >= 0 && tb_cyc > first_rsp1);
      check_output("t4_5th_wait", 32'(m1_bus.waitrequest), 32'(exp_wait));
      if (i == 1) begin
        check_output("t4_m0_wr_wait", 32'(m0_bus.waitrequest), 32'h0);
        check_output("t4_m0_s_write", 32'(s_bus.write), 32'h1);
        check_output("t4_m0_addr",    s_bus.address, 32'h3C);
      end
      if (m1_bus.waitrequest === 1'b0) begin
        exp1.push_back(pattern(32'h90));
        acc = 1'b1;
      end
      cycle();
    end
    idle(0);
    idle(1);
    check_output("t4_5th_accepted", 32'(acc), 32'h1);
    drain("t4", 30);

    // Reset while two reads are in flight; their late responses are strays
    apply_stimulus(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
    #1;
    check_output("t5_m0_wait", 32'(m0_bus.waitrequest), 32'h0);
    cycle();
    idle(0);
    apply_stimulus(1, 1'b1, 1'b0, 32'h80, 32'h0, 4'hF);
    #1;
    check_output("t5_m1_wait", 32'(m1_bus.waitrequest), 32'h0);
    cycle();
    idle(1);
    rst_n = 1'b0;
    apply_stimulus(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
    #1;
    check_output("t5_rst_m0_wait", 32'(m0_bus.waitrequest), 32'h1);
    check_output("t5_rst_m1_wait", 32'(m1_bus.waitrequest), 32'h1);
    check_output("t5_rst_s_read",  32'(s_bus.read), 32'h0);
    cycle();
    cycle();
    rst_n = 1'b1;
    apply_stimulus(0, 1'b0, 1'b1, 32'hC0, 32'hC0C0C0C0, 4'hF);
    apply_stimulus(1, 1'b0, 1'b1, 32'hC4, 32'hC4C4C4C4, 4'hF);
    #1;
    check_output("t5_tie_m0_wait", 32'(m0_bus.waitrequest), 32'h0);
    check_output("t5_tie_m1_wait", 32'(m1_bus.waitrequest), 32'h1);
    check_output("t5_tie_addr",    s_bus.address, 32'hC0);
    cycle();
    idle(0);
    #1;
    check_output("t5_tie2_m1_wait", 32'(m1_bus.waitrequest), 32'h0);
    cycle();
    idle(1);
    for (int i = 0; i < 10; i++) begin
      cycle();
      check_output("t5_quiet_m0_rdv", 32'(m0_bus.readdatavalid), 32'h0);
      check_output("t5_quiet_m1_rdv", 32'(m1_bus.readdatavalid), 32'h0);
    end
    lat = 1;
    apply_stimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    #1;
    check_output("t5_after_wait", 32'(m0_bus.waitrequest), 32'h0);
    if (m0_bus.waitrequest === 1'b0) exp0.push_back(32'hDEADBEEF);
    cycle();
    idle(0);
    drain("t5", 4);

    // Read and write together from m1: a byte-lane write only
    apply_stimulus(1, 1'b1, 1'b1, 32'h20, 32'h0000AB00, 4'h2);
    #1;
    check_output("t6_s_write", 32'(s_bus.write), 32'h1);
    check_output("t6_s_read",  32'(s_bus.read), 32'h0);
    check_output("t6_m1_wait", 32'(m1_bus.waitrequest), 32'h0);
    check_output("t6_s_be",    32'(s_bus.byteenable), 32'h2);
    cycle();
    check_output("t6_no_rdv", 32'(m1_bus.readdatavalid), 32'h0);
    idle(1);
    cycle();
    check_output("t6_no_rdv2", 32'(m1_bus.readdatavalid), 32'h0);
    apply_stimulus(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
    #1;
    if (m1_bus.waitrequest === 1'b0) exp1.push_back(32'h1122AB44);
    check_output("t6_rd_wait", 32'(m1_bus.waitrequest), 32'h0);
    cycle();
    idle(1);
    drain("t6", 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
